// File: rtl/sim_uart_pkg.sv
// Shared types for the simulation UART input responder.
// Byte type and the "no character available" marker.
package sim_uart_pkg;

    typedef logic [7:0] uart_ch_t;

    localparam uart_ch_t UART_NO_CHAR = 8'hFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// Character FIFO for the UART input responder.
// Extra pointer MSB distinguishes full from empty.
module sim_uart_fifo
    import sim_uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  uart_ch_t     push_ch,
    input  logic         pop,
    output uart_ch_t     head,
    output logic [AW:0]  level,
    output logic         full,
    output logic         empty
);

    uart_ch_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_ch;
    end

endmodule

// File: rtl/sim_uart_in_responder.sv
// Host-fed responder for the DUT UART input channel, optional baud gap.
// Define SIM_UART_IN_ECHO_EN to add the echo_valid/echo_ch outputs.
module sim_uart_in_responder
    import sim_uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int IDLE_GAP = 0,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          host_valid,
    input  uart_ch_t      host_ch,
    output logic          host_ready,
    input  logic          uart_in_valid,
    output uart_ch_t      uart_in_ch,
    output logic [LW-1:0] fifo_level,
    output logic [31:0]   delivered_cnt,
`ifdef SIM_UART_IN_ECHO_EN
    output logic [31:0]   empty_req_cnt,
    output logic          echo_valid,
    output uart_ch_t      echo_ch
`else
    output logic [31:0]   empty_req_cnt
`endif
);

    uart_ch_t    head;
    logic        full;
    logic        empty;
    logic        avail;
    logic        deliver;
    logic [31:0] gap_cnt;

    assign avail      = !empty && (gap_cnt == 32'd0);
    assign deliver    = uart_in_valid && avail;
    assign uart_in_ch = avail ? head : UART_NO_CHAR;
    assign host_ready = !full;

    sim_uart_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (host_valid && host_ready),
        .push_ch (host_ch),
        .pop     (deliver),
        .head    (head),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt       <= '0;
            delivered_cnt <= '0;
            empty_req_cnt <= '0;
        end else begin
            if (deliver) begin
                delivered_cnt <= delivered_cnt + 32'd1;
                gap_cnt       <= 32'(IDLE_GAP);
            end else begin
                if (uart_in_valid)
                    empty_req_cnt <= sat_inc(empty_req_cnt);
                if (gap_cnt != 32'd0)
                    gap_cnt <= gap_cnt - 32'd1;
            end
        end
    end

`ifdef SIM_UART_IN_ECHO_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            echo_valid <= 1'b0;
            echo_ch    <= 8'h00;
        end else begin
            echo_valid <= deliver;
            if (deliver) echo_ch <= head;
        end
    end
`endif

endmodule
